// File: rtl/clk_div_multi.sv
// Multi-channel 50% duty clock divider with per-channel enable and glitch-free
// runtime half-period updates deferred to each channel's terminal count.
module clk_div_multi #(
    parameter int          CHANNELS     = 2,
    parameter int          CNT_W        = 16,
    parameter int unsigned DEFAULT_HALF = 3999,
    parameter int          SEL_W        = 1
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [CHANNELS-1:0] EN,
    input  logic                DIV_WR,
    input  logic [SEL_W-1:0]    DIV_SEL,
    input  logic [CNT_W-1:0]    DIV_DATA,
    output logic [CHANNELS-1:0] CLK_OUT,
    output logic [CHANNELS-1:0] TICK,
    output logic [CHANNELS-1:0] PENDING
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] half;
        logic [CNT_W-1:0] pend_val;
        logic             pend;
        logic             out_lvl;
        logic             tick;
        logic             wr_hit;
        logic             tc;

        // Selects beyond the channel count never match any channel index.
        assign wr_hit = DIV_WR && (DIV_SEL == SEL_W'(g));
        assign tc     = (cnt == half);

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                cnt      <= '0;
                half     <= CNT_W'(DEFAULT_HALF);
                pend_val <= '0;
                pend     <= 1'b0;
                out_lvl  <= 1'b0;
                tick     <= 1'b0;
            end else begin
                if (EN[g]) begin
                    if (tc) begin
                        cnt     <= '0;
                        out_lvl <= ~out_lvl;
                        tick    <= 1'b1;
                    end else begin
                        cnt     <= cnt + CNT_W'(1);
                        tick    <= 1'b0;
                    end
                end else begin
                    cnt     <= '0;
                    out_lvl <= 1'b0;
                    tick    <= 1'b0;
                end

                // Old pending value lands first; a coincident write re-arms pend.
                if (pend && (!EN[g] || tc)) begin
                    half <= pend_val;
                    pend <= 1'b0;
                end
                if (wr_hit) begin
                    pend_val <= DIV_DATA;
                    pend     <= 1'b1;
                end
            end
        end

        assign CLK_OUT[g] = out_lvl;
        assign TICK[g]    = tick;
        assign PENDING[g] = pend;
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed testbench for clk_div_multi with three channels and a 2-bit select.
module tb_clk_div_multi;

    localparam int CH = 3;
    localparam int CW = 16;
    localparam int SW = 2;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic [CH-1:0] EN;
    logic          DIV_WR;
    logic [SW-1:0] DIV_SEL;
    logic [CW-1:0] DIV_DATA;
    logic [CH-1:0] CLK_OUT;
    logic [CH-1:0] TICK;
    logic [CH-1:0] PENDING;

    int total_cnt = 0;
    int pass_cnt  = 0;

    clk_div_multi #(
        .CHANNELS(CH), .CNT_W(CW), .DEFAULT_HALF(3999), .SEL_W(SW)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .DIV_WR(DIV_WR), .DIV_SEL(DIV_SEL),
        .DIV_DATA(DIV_DATA), .CLK_OUT(CLK_OUT), .TICK(TICK), .PENDING(PENDING)
    );

    always #5 CLK = ~CLK;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wait_tick(input int ch, input int bound, output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (!TICK[ch] && n < bound);
    endtask

    task automatic test_reset;
        RST_N = 1'b0; EN = '0; DIV_WR = 1'b0; DIV_SEL = '0; DIV_DATA = '0;
        #12;
        total_cnt++;
        if (CLK_OUT !== 3'b000) $display("FAIL reset_clk_out: got %b expected 000", CLK_OUT);
        else pass_cnt++;
        total_cnt++;
        if (TICK !== 3'b000) $display("FAIL reset_tick: got %b expected 000", TICK);
        else pass_cnt++;
        total_cnt++;
        if (PENDING !== 3'b000) $display("FAIL reset_pending: got %b expected 000", PENDING);
        else pass_cnt++;
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        EN    = 3'b001;
    endtask

    task automatic test_default;
        int ntick, t1, t2;
        logic c4000, c8000;
        logic [1:0] other;
        ntick = 0; t1 = 0; t2 = 0; c4000 = 1'b0; c8000 = 1'b1; other = '0;
        for (int e = 1; e <= 8000; e++) begin
            step(1);
            if (TICK[0]) begin
                ntick++;
                if (ntick == 1) t1 = e;
                else if (ntick == 2) t2 = e;
            end
            if (e == 4000) c4000 = CLK_OUT[0];
            if (e == 8000) c8000 = CLK_OUT[0];
            other |= CLK_OUT[2:1] | TICK[2:1];
        end
        total_cnt++;
        if (t1 !== 4000) $display("FAIL default_first_tick: got %0d expected 4000", t1);
        else pass_cnt++;
        total_cnt++;
        if (t2 !== 8000) $display("FAIL default_second_tick: got %0d expected 8000", t2);
        else pass_cnt++;
        total_cnt++;
        if (ntick !== 2) $display("FAIL default_tick_count: got %0d expected 2", ntick);
        else pass_cnt++;
        total_cnt++;
        if (c4000 !== 1'b1) $display("FAIL default_rise: got %b expected 1", c4000);
        else pass_cnt++;
        total_cnt++;
        if (c8000 !== 1'b0) $display("FAIL default_fall: got %b expected 0", c8000);
        else pass_cnt++;
        total_cnt++;
        if (other !== 2'b00) $display("FAIL default_idle_channels: got %b expected 00", other);
        else pass_cnt++;
    endtask

    task automatic test_pending_update;
        int n;
        logic dropped;
        EN = 3'b011;
        step(1000);
        DIV_WR = 1'b1; DIV_SEL = 2'd1; DIV_DATA = 16'd1;
        step(1);
        DIV_WR = 1'b0;
        total_cnt++;
        if (PENDING !== 3'b010) $display("FAIL upd_pending_set: got %b expected 010", PENDING);
        else pass_cnt++;
        n = 0; dropped = 1'b0;
        do begin
            step(1);
            n++;
            if (!TICK[1] && !PENDING[1]) dropped = 1'b1;
        end while (!TICK[1] && n < 5000);
        total_cnt++;
        if (n !== 2999) $display("FAIL upd_tc_edge: got %0d expected 2999", n);
        else pass_cnt++;
        total_cnt++;
        if (dropped !== 1'b0) $display("FAIL upd_pending_early_clear: got %b expected 0", dropped);
        else pass_cnt++;
        total_cnt++;
        if ({PENDING[1], CLK_OUT[1]} !== 2'b01) $display("FAIL upd_at_tc: got %b expected 01", {PENDING[1], CLK_OUT[1]});
        else pass_cnt++;
        step(1);
        total_cnt++;
        if (TICK[1] !== 1'b0) $display("FAIL upd_new_mid: got %b expected 0", TICK[1]);
        else pass_cnt++;
        step(1);
        total_cnt++;
        if ({TICK[1], CLK_OUT[1]} !== 2'b10) $display("FAIL upd_new_fall: got %b expected 10", {TICK[1], CLK_OUT[1]});
        else pass_cnt++;
        step(2);
        total_cnt++;
        if ({TICK[1], CLK_OUT[1]} !== 2'b11) $display("FAIL upd_new_rise: got %b expected 11", {TICK[1], CLK_OUT[1]});
        else pass_cnt++;
        EN = 3'b000;
        step(1);
        total_cnt++;
        if ({CLK_OUT, TICK} !== 6'b0) $display("FAIL upd_disable: got %b expected 000000", {CLK_OUT, TICK});
        else pass_cnt++;
    endtask

    task automatic test_half_zero;
        logic [5:0] pat, tk;
        DIV_WR = 1'b1; DIV_SEL = 2'd0; DIV_DATA = 16'd0;
        step(1);
        DIV_WR = 1'b0;
        total_cnt++;
        if (PENDING !== 3'b001) $display("FAIL h0_pending_set: got %b expected 001", PENDING);
        else pass_cnt++;
        step(1);
        total_cnt++;
        if (PENDING !== 3'b000) $display("FAIL h0_idle_apply: got %b expected 000", PENDING);
        else pass_cnt++;
        EN = 3'b001;
        for (int i = 0; i < 6; i++) begin
            step(1);
            pat[i] = CLK_OUT[0];
            tk[i]  = TICK[0];
        end
        total_cnt++;
        if (pat !== 6'b010101) $display("FAIL h0_clk_pattern: got %b expected 010101", pat);
        else pass_cnt++;
        total_cnt++;
        if (tk !== 6'b111111) $display("FAIL h0_tick_held: got %b expected 111111", tk);
        else pass_cnt++;
    endtask

    task automatic test_disable_restart;
        int n;
        EN = 3'b000;
        DIV_WR = 1'b1; DIV_SEL = 2'd0; DIV_DATA = 16'd199;
        step(1);
        DIV_WR = 1'b0;
        step(1);
        EN = 3'b001;
        step(300);
        total_cnt++;
        if (CLK_OUT[0] !== 1'b1) $display("FAIL dis_running_high: got %b expected 1", CLK_OUT[0]);
        else pass_cnt++;
        EN = 3'b000;
        step(1);
        total_cnt++;
        if ({CLK_OUT[0], TICK[0]} !== 2'b00) $display("FAIL dis_cleared: got %b expected 00", {CLK_OUT[0], TICK[0]});
        else pass_cnt++;
        EN = 3'b001;
        wait_tick(0, 1000, n);
        total_cnt++;
        if (n !== 200) $display("FAIL dis_restart_edge: got %0d expected 200", n);
        else pass_cnt++;
        total_cnt++;
        if (CLK_OUT[0] !== 1'b1) $display("FAIL dis_restart_rise: got %b expected 1", CLK_OUT[0]);
        else pass_cnt++;
    endtask

    task automatic test_coincident;
        int n;
        EN = 3'b000;
        DIV_WR = 1'b1; DIV_SEL = 2'd0; DIV_DATA = 16'd3;
        step(1);
        DIV_WR = 1'b0;
        step(1);
        EN = 3'b001;
        step(1);
        DIV_WR = 1'b1; DIV_DATA = 16'd5;
        step(1);
        DIV_WR = 1'b0;
        step(1);
        DIV_WR = 1'b1; DIV_DATA = 16'd7;
        step(1);
        DIV_WR = 1'b0;
        total_cnt++;
        if ({TICK[0], PENDING[0]} !== 2'b11) $display("FAIL coin_tc: got %b expected 11", {TICK[0], PENDING[0]});
        else pass_cnt++;
        wait_tick(0, 100, n);
        total_cnt++;
        if (n !== 6) $display("FAIL coin_period5: got %0d expected 6", n);
        else pass_cnt++;
        total_cnt++;
        if (PENDING[0] !== 1'b0) $display("FAIL coin_pending_clear: got %b expected 0", PENDING[0]);
        else pass_cnt++;
        wait_tick(0, 100, n);
        total_cnt++;
        if (n !== 8) $display("FAIL coin_period7: got %0d expected 8", n);
        else pass_cnt++;
    endtask

    task automatic test_bad_sel;
        int f0, f1, f2;
        EN = 3'b000;
        step(2);
        DIV_WR = 1'b1; DIV_SEL = 2'd3; DIV_DATA = 16'd0;
        step(1);
        DIV_WR = 1'b0;
        total_cnt++;
        if (PENDING !== 3'b000) $display("FAIL badsel_pending: got %b expected 000", PENDING);
        else pass_cnt++;
        step(1);
        total_cnt++;
        if (PENDING !== 3'b000) $display("FAIL badsel_pending_later: got %b expected 000", PENDING);
        else pass_cnt++;
        EN = 3'b111;
        f0 = 0; f1 = 0; f2 = 0;
        for (int e = 1; e <= 8; e++) begin
            step(1);
            if (TICK[0] && f0 == 0) f0 = e;
            if (TICK[1] && f1 == 0) f1 = e;
            if (TICK[2] && f2 == 0) f2 = e;
        end
        total_cnt++;
        if (f0 !== 8) $display("FAIL badsel_ch0_period: got %0d expected 8", f0);
        else pass_cnt++;
        total_cnt++;
        if (f1 !== 2) $display("FAIL badsel_ch1_period: got %0d expected 2", f1);
        else pass_cnt++;
        total_cnt++;
        if (f2 !== 0) $display("FAIL badsel_ch2_period: got %0d expected 0", f2);
        else pass_cnt++;
    endtask

    task automatic test_async_reset;
        int n;
        DIV_WR = 1'b1; DIV_SEL = 2'd2; DIV_DATA = 16'd50;
        step(1);
        DIV_WR = 1'b0;
        total_cnt++;
        if ({CLK_OUT, PENDING} !== 6'b001_100) $display("FAIL arst_pre_state: got %b expected 001100", {CLK_OUT, PENDING});
        else pass_cnt++;
        #2;
        RST_N = 1'b0;
        #1;
        total_cnt++;
        if ({CLK_OUT, TICK, PENDING} !== 9'b0) $display("FAIL arst_async_clear: got %b expected 000000000", {CLK_OUT, TICK, PENDING});
        else pass_cnt++;
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        EN    = 3'b001;
        wait_tick(0, 5000, n);
        total_cnt++;
        if (n !== 4000) $display("FAIL arst_default_half: got %0d expected 4000", n);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_default();
        test_pending_update();
        test_half_zero();
        test_disable_restart();
        test_coincident();
        test_bad_sel();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
